handshake_constant_seq: RTL and testbench
=========================================

# handshake_constant_seq

Parametrised successor to the single-constant handshake source: every token accepted on the control channel emits the next word of a compile-time constant table, cycling through the table modulo DEPTH. The block sits in the dataflow fabric wherever a fixed coefficient sequence, address stride pattern or tag stream is needed per control token. When REGISTERED=1, a two-entry skid buffer cuts the combinational valid/ready path between the control and output channels.

## Interface
- DATA_WIDTH, 32: width of each constant word.
- DEPTH, 4: number of table entries, at least 1.
- VALUES, 0: packed DEPTH*DATA_WIDTH table; entry i = VALUES[i*DATA_WIDTH +: DATA_WIDTH].
- REGISTERED, 1: 1 = skid-buffered output; 0 = combinational pass-through.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- restart  input  1  synchronous pulse; returns the table index to 0.
- ctrl_valid  input  1  control token present.
- ctrl_ready  output  1  control token can be taken.
- outs  output  DATA_WIDTH  emitted constant.
- outs_valid  output  1  outs holds a word.
- outs_ready  input  1  consumer accepts outs.
- idx  output  IDX_W  table index used by the next accepted token (debug/observability).

## Operation
- Token accept: ctrl_valid && ctrl_ready. The accepted token is bound to VALUES entry idx.
- Index: on accept, idx <= (idx == DEPTH-1) ? 0 : idx+1. When DEPTH=1, idx stays 0.
- restart: idx <= 0 on the next edge. It takes priority over the increment. A token accepted in the same cycle still uses the pre-restart idx. Words already buffered are unaffected.
- REGISTERED=0:
  - outs = VALUES[idx], outs_valid = ctrl_valid, ctrl_ready = outs_ready.
  - Accept happens exactly when the output transfer happens.
- REGISTERED=1: two-entry skid buffer (main, skid).
  - ctrl_ready = !skid_valid, driven from a register.
  - An accepted word goes to main if main is empty or draining this cycle; otherwise it goes to skid.
  - outs/outs_valid come from main. When main drains, skid moves into main.
- No word is dropped or duplicated. Output order equals accept order.
- Reset (rst low, any time): idx=0, main_valid=0, skid_valid=0. Buffered words are discarded.
  - Reset values: outs_valid=0; ctrl_ready=1 when REGISTERED=1, outs_ready when REGISTERED=0; outs=VALUES entry 0 when REGISTERED=0, all-zeros when REGISTERED=1.

## Timing
- REGISTERED=0: zero-cycle latency; fully combinational from ctrl_valid/outs_ready to the outputs.
- REGISTERED=1:
  - Latency: token accepted at edge N gives outs_valid high from after edge N.
  - Throughput: 1 word/cycle sustained while outs_ready=1.
  - ctrl_ready depends only on registers; no ctrl_valid->outs_valid or outs_ready->ctrl_ready combinational path.
- Full condition: skid_valid=1 forces ctrl_ready=0. Skid fills only when main is valid and outs_ready=0 in an accept cycle.
- Empty condition: outs_valid=0; a new accept fills main.
- Simultaneous accept and drain while full is impossible, because ctrl_ready=0 when full.
- Simultaneous accept and drain while main-only: main is replaced in place, skid stays empty.
- Valid stability: once outs_valid=1, outs and outs_valid stay constant until outs_ready=1.

## Structure
- Shared package handshake_pkg:
  - function clog2_min1(n), giving IDX_W = max(1, clog2(DEPTH)).
  - helper function returning table entry i from a packed VALUES vector.
- Sub-module handshake_skid_buffer #(DATA_WIDTH): generic two-entry elastic buffer with in/out valid/ready, reusable elsewhere.
  - Instantiated only under generate REGISTERED=1.
- Index counter and restart logic live in the top module.

## Test plan
Configuration: DATA_WIDTH=8, DEPTH=3, VALUES={8'h33,8'h22,8'h11} (entry0=0x11).
1. Reset release, ctrl_valid=1 and outs_ready=1 held for 7 cycles -> outs sequence 11,22,33,11,22,33,11 on consecutive cycles, starting one cycle after first accept (REGISTERED=1).
2. Same stimulus with REGISTERED=0 -> identical sequence with zero latency; ctrl_ready tracks outs_ready each cycle.
3. outs_ready=0 with ctrl_valid=1 -> exactly two accepts (11, 22), then ctrl_ready=0 and outs holds 11. Raise outs_ready -> 11, 22, 33 in order with no loss.
4. After two accepts (idx=2), pulse restart together with a third accept -> third word is 33, idx=0 next cycle, following word is 11.
5. Assert rst mid-stream with skid full -> outs_valid=0 and idx=0 immediately (asynchronous); after release the first word out is 11.
6. DEPTH=1, VALUES=8'hA5, random ctrl_valid/outs_ready for 1000 cycles -> every output word is A5, output count equals accept count, no valid drop under stall.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake constant-sequence blocks.
package handshake_pkg;

    // Upper bounds for the generic table accessor below.
    localparam int unsigned MAX_TABLE_W = 4096;
    localparam int unsigned MAX_WORD_W  = 256;

    // Index width that never collapses to zero bits (DEPTH=1 still gets 1 bit).
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Entry i of a packed table of width-bit words; caller truncates to its width.
    function automatic logic [MAX_WORD_W-1:0] table_entry(
        input logic [MAX_TABLE_W-1:0] values,
        input int unsigned            width,
        input int unsigned            i
    );
        return MAX_WORD_W'(values >> (i * width));
    endfunction

endpackage

// File: rtl/handshake_constant_seq_if.sv
// Control-token and output-word handshake bundle.
interface handshake_constant_seq_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;

    // Producer of tokens / consumer of words.
    modport master (
        output ctrl_valid,
        output outs_ready,
        input  ctrl_ready,
        input  outs,
        input  outs_valid
    );

    // The sequencer itself.
    modport slave (
        input  ctrl_valid,
        input  outs_ready,
        output ctrl_ready,
        output outs,
        output outs_valid
    );
endinterface

// File: rtl/handshake_skid_buffer.sv
// Two-entry elastic buffer: registered in_ready, outputs from the main register.
module handshake_skid_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  main_valid, main_valid_next;
    logic                  skid_valid, skid_valid_next;
    logic [DATA_WIDTH-1:0] main_data, main_data_next;
    logic [DATA_WIDTH-1:0] skid_data, skid_data_next;
    logic                  accept;
    logic                  drain;

    assign accept = in_valid && !skid_valid;
    assign drain  = main_valid && out_ready;

    // Next-state: fill main when empty/draining, spill to skid otherwise, refill main from skid.
    always_comb begin
        main_valid_next = main_valid;
        skid_valid_next = skid_valid;
        main_data_next  = main_data;
        skid_data_next  = skid_data;
        if (skid_valid) begin
            if (drain) begin
                main_data_next  = skid_data;
                skid_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || drain) begin
                main_valid_next = 1'b1;
                main_data_next  = in_data;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = in_data;
            end
        end else if (drain) begin
            main_valid_next = 1'b0;
        end
    end

    // Buffer state registers; reset discards any held words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_next;
            skid_valid <= skid_valid_next;
            main_data  <= main_data_next;
            skid_data  <= skid_data_next;
        end
    end

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits the next word of a constant table for every accepted control token.
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int unsigned                   DATA_WIDTH = 32,
    parameter int unsigned                   DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   VALUES     = '0,
    parameter bit                            REGISTERED = 1'b1,
    localparam int unsigned                  IDX_W      = clog2_min1(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    handshake_constant_seq_if.slave bus,
    output logic [IDX_W-1:0]     idx
);

    logic [DATA_WIDTH-1:0] word;
    logic [IDX_W-1:0]      idx_next;
    logic                  accept;

    assign word   = DATA_WIDTH'(table_entry(MAX_TABLE_W'(VALUES), DATA_WIDTH, 32'(idx)));
    assign accept = bus.ctrl_valid && bus.ctrl_ready;

    // Restart wins over the wrap-around increment; the accepted token already used idx.
    always_comb begin
        idx_next = idx;
        if (restart) begin
            idx_next = '0;
        end else if (accept) begin
            idx_next = (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    // Table index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else begin
            idx <= idx_next;
        end
    end

    if (REGISTERED) begin : g_registered
        handshake_skid_buffer #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_skid (
            .clk      (clk),
            .rst_n    (rst),
            .in_valid (bus.ctrl_valid),
            .in_ready (bus.ctrl_ready),
            .in_data  (word),
            .out_valid(bus.outs_valid),
            .out_ready(bus.outs_ready),
            .out_data (bus.outs)
        );
    end else begin : g_passthrough
        assign bus.outs       = word;
        assign bus.outs_valid = bus.ctrl_valid;
        assign bus.ctrl_ready = bus.outs_ready;
    end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: registered, pass-through and single-entry variants.
module tb_handshake_constant_seq;

    localparam logic [7:0] TBL [3] = '{8'h11, 8'h22, 8'h33};
    localparam logic [7:0] SEQ [7] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 8'h11};

    logic       clk;
    logic       rst;
    logic       restart_r, restart_c, restart_1;
    logic [1:0] idx_r, idx_c;
    logic [0:0] idx_1;

    handshake_constant_seq_if #(.DATA_WIDTH(8)) bus_r ();
    handshake_constant_seq_if #(.DATA_WIDTH(8)) bus_c ();
    handshake_constant_seq_if #(.DATA_WIDTH(8)) bus_1 ();

    handshake_constant_seq #(
        .DATA_WIDTH(8), .DEPTH(3), .VALUES(24'h332211), .REGISTERED(1'b1)
    ) u_reg (
        .clk(clk), .rst(rst), .restart(restart_r), .bus(bus_r), .idx(idx_r)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(8), .DEPTH(3), .VALUES(24'h332211), .REGISTERED(1'b0)
    ) u_comb (
        .clk(clk), .rst(rst), .restart(restart_c), .bus(bus_c), .idx(idx_c)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(8), .DEPTH(1), .VALUES(8'hA5), .REGISTERED(1'b1)
    ) u_one (
        .clk(clk), .rst(rst), .restart(restart_1), .bus(bus_1), .idx(idx_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: FIFO of words owed to the consumer, capacity 2 when registered.
    logic [7:0] q_r [$];
    logic [7:0] q_1 [$];
    logic [7:0] got [$];
    int         m_idx_r = 0;
    int         m_idx_c = 0;

    task automatic model_edge_reg(input logic cv, input logic ordy, input logic rs);
        logic acc, drn;
        acc = cv && (q_r.size() < 2);
        drn = ordy && (q_r.size() > 0);
        if (drn) void'(q_r.pop_front());
        if (acc) begin
            q_r.push_back(TBL[m_idx_r]);
            m_idx_r = (m_idx_r + 1) % 3;
        end
        if (rs) m_idx_r = 0;
    endtask

    task automatic idle_all();
        bus_r.ctrl_valid = 1'b0; bus_r.outs_ready = 1'b0; restart_r = 1'b0;
        bus_c.ctrl_valid = 1'b0; bus_c.outs_ready = 1'b0; restart_c = 1'b0;
        bus_1.ctrl_valid = 1'b0; bus_1.outs_ready = 1'b0; restart_1 = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        q_r.delete(); q_1.delete(); got.delete();
        m_idx_r = 0; m_idx_c = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++; if (bus_r.outs_valid !== 1'b0) begin bad++; $display("FAIL reset_reg_valid got=%b want=0", bus_r.outs_valid); end
        total++; if (bus_r.ctrl_ready !== 1'b1) begin bad++; $display("FAIL reset_reg_ready got=%b want=1", bus_r.ctrl_ready); end
        total++; if (bus_r.outs !== 8'h00) begin bad++; $display("FAIL reset_reg_outs got=%h want=00", bus_r.outs); end
        total++; if (idx_r !== 2'd0) begin bad++; $display("FAIL reset_reg_idx got=%0d want=0", idx_r); end
        total++; if (bus_c.outs !== 8'h11) begin bad++; $display("FAIL reset_comb_outs got=%h want=11", bus_c.outs); end
        total++; if (bus_c.outs_valid !== 1'b0) begin bad++; $display("FAIL reset_comb_valid got=%b want=0", bus_c.outs_valid); end
        bus_c.outs_ready = 1'b1; #1;
        total++; if (bus_c.ctrl_ready !== 1'b1) begin bad++; $display("FAIL reset_comb_ready got=%b want=1", bus_c.ctrl_ready); end
        total++; if (bus_1.outs_valid !== 1'b0 || bus_1.ctrl_ready !== 1'b1) begin
            bad++; $display("FAIL reset_one valid=%b ready=%b want valid=0 ready=1", bus_1.outs_valid, bus_1.ctrl_ready);
        end
        bus_c.outs_ready = 1'b0;
    endtask

    task automatic test_stream_reg();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            logic cv;
            cv = (i < 7);
            @(negedge clk);
            bus_r.ctrl_valid = cv; bus_r.outs_ready = 1'b1; restart_r = 1'b0; #1;
            total++; if (bus_r.outs_valid !== (q_r.size() > 0)) begin bad++; $display("FAIL stream_reg_valid cyc=%0d got=%b want=%b", i, bus_r.outs_valid, q_r.size() > 0); end
            if (q_r.size() > 0) begin total++; if (bus_r.outs !== q_r[0]) begin bad++; $display("FAIL stream_reg_outs cyc=%0d got=%h want=%h", i, bus_r.outs, q_r[0]); end end
            total++; if (bus_r.ctrl_ready !== (q_r.size() < 2)) begin bad++; $display("FAIL stream_reg_ready cyc=%0d got=%b want=%b", i, bus_r.ctrl_ready, q_r.size() < 2); end
            total++; if (idx_r !== 2'(m_idx_r)) begin bad++; $display("FAIL stream_reg_idx cyc=%0d got=%0d want=%0d", i, idx_r, m_idx_r); end
            if (bus_r.outs_valid) got.push_back(bus_r.outs);
            if (i == 0) begin total++; if (bus_r.outs_valid !== 1'b0) begin bad++; $display("FAIL stream_reg_latency got=%b want=0", bus_r.outs_valid); end end
            model_edge_reg(cv, 1'b1, 1'b0);
        end
        total++; if (got.size() != 7) begin bad++; $display("FAIL stream_reg_count got=%0d want=7", got.size()); end
        for (int k = 0; k < 7 && k < got.size(); k++) begin
            total++; if (got[k] !== SEQ[k]) begin bad++; $display("FAIL stream_reg_seq k=%0d got=%h want=%h", k, got[k], SEQ[k]); end
        end
    endtask

    task automatic test_stream_comb();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            logic cv, ordy;
            cv   = (i < 7) ? 1'b1 : 1'($urandom_range(0, 1));
            ordy = (i < 7) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            bus_c.ctrl_valid = cv; bus_c.outs_ready = ordy; restart_c = 1'b0; #1;
            total++; if (bus_c.outs !== TBL[m_idx_c]) begin bad++; $display("FAIL comb_outs cyc=%0d got=%h want=%h", i, bus_c.outs, TBL[m_idx_c]); end
            total++; if (bus_c.outs_valid !== cv) begin bad++; $display("FAIL comb_valid cyc=%0d got=%b want=%b", i, bus_c.outs_valid, cv); end
            total++; if (bus_c.ctrl_ready !== ordy) begin bad++; $display("FAIL comb_ready cyc=%0d got=%b want=%b", i, bus_c.ctrl_ready, ordy); end
            total++; if (idx_c !== 2'(m_idx_c)) begin bad++; $display("FAIL comb_idx cyc=%0d got=%0d want=%0d", i, idx_c, m_idx_c); end
            if (i < 7 && bus_c.outs_valid && ordy) got.push_back(bus_c.outs);
            if (cv && ordy) m_idx_c = (m_idx_c + 1) % 3;
        end
        total++; if (got.size() != 7) begin bad++; $display("FAIL comb_count got=%0d want=7", got.size()); end
        for (int k = 0; k < 7 && k < got.size(); k++) begin
            total++; if (got[k] !== SEQ[k]) begin bad++; $display("FAIL comb_seq k=%0d got=%h want=%h", k, got[k], SEQ[k]); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            logic cv, ordy;
            cv   = (i < 7);
            ordy = (i >= 4);
            @(negedge clk);
            bus_r.ctrl_valid = cv; bus_r.outs_ready = ordy; restart_r = 1'b0; #1;
            total++; if (bus_r.outs_valid !== (q_r.size() > 0)) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=%b", i, bus_r.outs_valid, q_r.size() > 0); end
            if (q_r.size() > 0) begin total++; if (bus_r.outs !== q_r[0]) begin bad++; $display("FAIL stall_outs cyc=%0d got=%h want=%h", i, bus_r.outs, q_r[0]); end end
            total++; if (bus_r.ctrl_ready !== (q_r.size() < 2)) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b want=%b", i, bus_r.ctrl_ready, q_r.size() < 2); end
            total++; if (idx_r !== 2'(m_idx_r)) begin bad++; $display("FAIL stall_idx cyc=%0d got=%0d want=%0d", i, idx_r, m_idx_r); end
            if (i == 3) begin
                total++; if (bus_r.ctrl_ready !== 1'b0 || bus_r.outs !== 8'h11) begin
                    bad++; $display("FAIL stall_full ready=%b outs=%h want ready=0 outs=11", bus_r.ctrl_ready, bus_r.outs);
                end
            end
            if (bus_r.outs_valid && ordy) got.push_back(bus_r.outs);
            model_edge_reg(cv, ordy, 1'b0);
        end
        total++; if (got.size() < 3) begin bad++; $display("FAIL stall_drain_count got=%0d want>=3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            total++; if (got[k] !== TBL[k]) begin bad++; $display("FAIL stall_order k=%0d got=%h want=%h", k, got[k], TBL[k]); end
        end
    endtask

    task automatic test_restart();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            logic cv, rs;
            cv = (i < 4);
            rs = (i == 2);
            @(negedge clk);
            bus_r.ctrl_valid = cv; bus_r.outs_ready = 1'b1; restart_r = rs; #1;
            total++; if (bus_r.outs_valid !== (q_r.size() > 0)) begin bad++; $display("FAIL restart_valid cyc=%0d got=%b want=%b", i, bus_r.outs_valid, q_r.size() > 0); end
            if (q_r.size() > 0) begin total++; if (bus_r.outs !== q_r[0]) begin bad++; $display("FAIL restart_outs cyc=%0d got=%h want=%h", i, bus_r.outs, q_r[0]); end end
            total++; if (idx_r !== 2'(m_idx_r)) begin bad++; $display("FAIL restart_idx cyc=%0d got=%0d want=%0d", i, idx_r, m_idx_r); end
            if (i == 3) begin total++; if (idx_r !== 2'd0) begin bad++; $display("FAIL restart_idx_zero got=%0d want=0", idx_r); end end
            if (bus_r.outs_valid) got.push_back(bus_r.outs);
            model_edge_reg(cv, 1'b1, rs);
        end
        total++; if (got.size() != 4) begin bad++; $display("FAIL restart_count got=%0d want=4", got.size()); end
        if (got.size() == 4) begin
            total++; if (got[2] !== 8'h33) begin bad++; $display("FAIL restart_third got=%h want=33", got[2]); end
            total++; if (got[3] !== 8'h11) begin bad++; $display("FAIL restart_fourth got=%h want=11", got[3]); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_r.ctrl_valid = 1'b1; bus_r.outs_ready = 1'b0; restart_r = 1'b0; #1;
            total++; if (bus_r.ctrl_ready !== (q_r.size() < 2)) begin bad++; $display("FAIL areset_fill_ready cyc=%0d got=%b want=%b", i, bus_r.ctrl_ready, q_r.size() < 2); end
            model_edge_reg(1'b1, 1'b0, 1'b0);
        end
        @(negedge clk); #1;
        total++; if (bus_r.ctrl_ready !== 1'b0 || idx_r !== 2'(m_idx_r)) begin
            bad++; $display("FAIL areset_full ready=%b idx=%0d want ready=0 idx=%0d", bus_r.ctrl_ready, idx_r, m_idx_r);
        end
        #1 rst = 1'b0;
        #1;
        total++; if (bus_r.outs_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", bus_r.outs_valid); end
        total++; if (idx_r !== 2'd0) begin bad++; $display("FAIL areset_idx got=%0d want=0", idx_r); end
        total++; if (bus_r.ctrl_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b want=1", bus_r.ctrl_ready); end
        q_r.delete(); m_idx_r = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_r.ctrl_valid = 1'b1; bus_r.outs_ready = 1'b1; #1;
            if (bus_r.outs_valid) got.push_back(bus_r.outs);
            model_edge_reg(1'b1, 1'b1, 1'b0);
        end
        total++; if (got.size() == 0) begin bad++; $display("FAIL areset_first got=none want=11"); end
        else if (got[0] !== 8'h11) begin bad++; $display("FAIL areset_first got=%h want=11", got[0]); end
    endtask

    task automatic test_random_reg();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic cv, ordy, rs;
            cv   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            rs   = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            bus_r.ctrl_valid = cv; bus_r.outs_ready = ordy; restart_r = rs; #1;
            total++; if (bus_r.outs_valid !== (q_r.size() > 0)) begin bad++; $display("FAIL rand_reg_valid cyc=%0d got=%b want=%b", i, bus_r.outs_valid, q_r.size() > 0); end
            if (q_r.size() > 0) begin total++; if (bus_r.outs !== q_r[0]) begin bad++; $display("FAIL rand_reg_outs cyc=%0d got=%h want=%h", i, bus_r.outs, q_r[0]); end end
            total++; if (bus_r.ctrl_ready !== (q_r.size() < 2)) begin bad++; $display("FAIL rand_reg_ready cyc=%0d got=%b want=%b", i, bus_r.ctrl_ready, q_r.size() < 2); end
            total++; if (idx_r !== 2'(m_idx_r)) begin bad++; $display("FAIL rand_reg_idx cyc=%0d got=%0d want=%0d", i, idx_r, m_idx_r); end
            model_edge_reg(cv, ordy, rs);
        end
    endtask

    task automatic test_depth1_random();
        int n_acc, n_out;
        apply_reset();
        n_acc = 0; n_out = 0;
        for (int i = 0; i < 1010; i++) begin
            logic cv, ordy, rs, acc, drn;
            cv   = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            rs   = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            bus_1.ctrl_valid = cv; bus_1.outs_ready = ordy; restart_1 = rs; #1;
            total++; if (bus_1.outs_valid !== (q_1.size() > 0)) begin bad++; $display("FAIL one_valid cyc=%0d got=%b want=%b", i, bus_1.outs_valid, q_1.size() > 0); end
            if (q_1.size() > 0) begin total++; if (bus_1.outs !== 8'hA5) begin bad++; $display("FAIL one_outs cyc=%0d got=%h want=a5", i, bus_1.outs); end end
            total++; if (bus_1.ctrl_ready !== (q_1.size() < 2)) begin bad++; $display("FAIL one_ready cyc=%0d got=%b want=%b", i, bus_1.ctrl_ready, q_1.size() < 2); end
            total++; if (idx_1 !== 1'b0) begin bad++; $display("FAIL one_idx cyc=%0d got=%0d want=0", i, idx_1); end
            if (cv && bus_1.ctrl_ready) n_acc++;
            if (bus_1.outs_valid && ordy) n_out++;
            acc = cv && (q_1.size() < 2);
            drn = ordy && (q_1.size() > 0);
            if (drn) void'(q_1.pop_front());
            if (acc) q_1.push_back(8'hA5);
        end
        total++; if (n_out != n_acc) begin bad++; $display("FAIL one_conservation outs=%0d accepts=%0d", n_out, n_acc); end
    endtask

    initial begin
        rst = 1'b0;
        idle_all();
        test_reset();
        test_stream_reg();
        test_stream_comb();
        test_stall();
        test_restart();
        test_async_reset();
        test_random_reg();
        test_depth1_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
